// File: rtl/lsu_mem_ctrl.sv
// Load/store controller for the single-port word data RAM.
// Ports: req_* handshake in, rsp_* result out, mem_* to the RAM rw port.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_rw,
    input  logic [31:0]       mem_dout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_CAP   = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       data_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              we_q;

    logic              accept;
    logic              req_err;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       lane_ext;
    logic [31:0]       merged;
    logic              unused_addr;

    // High address bits wrap away by design.
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state == S_RESP);
    assign mem_addr  = addr_q[ADDR_W+1:2];
    assign mem_din   = data_q;
    // Held in read mode during reset so a reset edge never writes RAM.
    assign mem_rw    = ~(rst_n & (state == S_WR));

    always_comb begin
        req_err = 1'b0;
        unique case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    assign lane_b = mem_dout[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = mem_dout[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        lane_ext = mem_dout;
        unique case (size_q)
            2'b00:   lane_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
            2'b01:   lane_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: lane_ext = mem_dout;
        endcase
    end

    // Sub-word store: overwrite only the addressed lane of the old word.
    always_comb begin
        merged = mem_dout;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr[ADDR_W+1:0];
                        data_q <= req_wdata;
                        size_q <= req_size;
                        uns_q  <= req_unsigned;
                        we_q   <= req_we;
                        if (req_err) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= S_RESP;
                        end else if (req_we && req_size == 2'b10) begin
                            state <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD:    state <= we_q ? S_MERGE : S_CAP;
                S_MERGE: begin
                    data_q <= merged;
                    state  <= S_WR;
                end
                S_CAP: begin
                    rsp_rdata <= lane_ext;
                    rsp_err   <= 1'b0;
                    state     <= S_RESP;
                end
                S_WR: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    state     <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl with a behavioural 32-word RAM.
// Directed vector table plus reset and abort sequences.
module tb_lsu_mem_ctrl;

    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              mem_rw;
    logic [31:0]       mem_dout;

    logic [31:0] mem [32];
    logic [31:0] snap [32];
    int          wr_cnt = 0;
    int          last_wa = -1;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nwr;
    } vec_t;

    vec_t vecs [25];

    lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_rw(mem_rw), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_rw) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (!mem_rw) begin
            wr_cnt  = wr_cnt + 1;
            last_wa = int'(mem_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        int  lat;
        bit  got;
        int  w0;
        logic [31:0] held;
        string tag;
        tag = $sformatf("v%0d", idx);
        lat = 0;
        got = 1'b0;
        @(negedge clk);
        chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        w0           = wr_cnt;
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        @(posedge clk);
        #1;
        // Garbage while busy must be ignored.
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h0000_001C;
        req_wdata = 32'hBAD0_BAD0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                lat = i;
            end
        end
        req_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: no rsp_valid within 8 cycles", tag);
            return;
        end
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " err"}, {31'd0, rsp_err}, {31'd0, v.err});
        chk({tag, " rdata"}, rsp_rdata, v.rdata);
        chk({tag, " writes"}, wr_cnt - w0, v.nwr);
        if (v.nwr > 0)
            chk({tag, " wr_addr"}, last_wa, {27'd0, v.addr[6:2]});
        held = rsp_rdata;
        @(negedge clk);
        chk({tag, " pulse"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, " hold"}, rsp_rdata, held);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 | i;
        mem[0] = 32'h1122_3344;

        //           we  sz    u  addr          wdata          e  rdata          lat nwr
        vecs[0]  = '{1, 2'b10, 0, 32'h10,       32'hDEADBEEF, 0, 32'h0,        2, 1};
        vecs[1]  = '{0, 2'b10, 0, 32'h10,       32'h0,        0, 32'hDEADBEEF, 3, 0};
        vecs[2]  = '{1, 2'b00, 0, 32'h12,       32'hAAAAAA55, 0, 32'h0,        4, 1};
        vecs[3]  = '{0, 2'b10, 0, 32'h10,       32'h0,        0, 32'hDE55BEEF, 3, 0};
        vecs[4]  = '{0, 2'b00, 0, 32'h13,       32'h0,        0, 32'hFFFFFFDE, 3, 0};
        vecs[5]  = '{0, 2'b00, 1, 32'h13,       32'h0,        0, 32'h000000DE, 3, 0};
        vecs[6]  = '{1, 2'b10, 1, 32'h08,       32'h80017FFF, 0, 32'h0,        2, 1};
        vecs[7]  = '{0, 2'b01, 0, 32'h0A,       32'h0,        0, 32'hFFFF8001, 3, 0};
        vecs[8]  = '{0, 2'b01, 1, 32'h08,       32'h0,        0, 32'h00007FFF, 3, 0};
        vecs[9]  = '{0, 2'b01, 0, 32'h08,       32'h0,        0, 32'h00007FFF, 3, 0};
        vecs[10] = '{0, 2'b10, 1, 32'h08,       32'h0,        0, 32'h80017FFF, 3, 0};
        vecs[11] = '{0, 2'b10, 0, 32'h06,       32'h0,        1, 32'h0,        1, 0};
        vecs[12] = '{1, 2'b01, 0, 32'h03,       32'h12345678, 1, 32'h0,        1, 0};
        vecs[13] = '{0, 2'b11, 0, 32'h00,       32'h0,        1, 32'h0,        1, 0};
        vecs[14] = '{0, 2'b10, 0, 32'h10,       32'h0,        0, 32'hDE55BEEF, 3, 0};
        vecs[15] = '{1, 2'b01, 1, 32'h12,       32'h1234A5A5, 0, 32'h0,        4, 1};
        vecs[16] = '{0, 2'b10, 0, 32'h10,       32'h0,        0, 32'hA5A5BEEF, 3, 0};
        vecs[17] = '{1, 2'b00, 0, 32'h11,       32'hFFFFFF7F, 0, 32'h0,        4, 1};
        vecs[18] = '{0, 2'b10, 0, 32'h10,       32'h0,        0, 32'hA5A57FEF, 3, 0};
        vecs[19] = '{0, 2'b00, 0, 32'h11,       32'h0,        0, 32'h0000007F, 3, 0};
        vecs[20] = '{0, 2'b00, 0, 32'h10,       32'h0,        0, 32'hFFFFFFEF, 3, 0};
        vecs[21] = '{1, 2'b10, 0, 32'h84,       32'h12345678, 0, 32'h0,        2, 1};
        vecs[22] = '{0, 2'b10, 0, 32'h04,       32'h0,        0, 32'h12345678, 3, 0};
        vecs[23] = '{0, 2'b10, 0, 32'hFFFF0004, 32'h0,        0, 32'h12345678, 3, 0};
        vecs[24] = '{0, 2'b00, 0, 32'h12,       32'h0,        0, 32'hFFFFFFA5, 3, 0};

        // Reset with a garbage store request held.
        rst_n        = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h10;
        req_wdata    = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) snap[i] = mem[i];
        @(negedge clk);
        chk("rst mem_rw0", {31'd0, mem_rw}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst ready%0d", c), {31'd0, req_ready}, 32'd1);
            chk($sformatf("rst valid%0d", c), {31'd0, rsp_valid}, 32'd0);
            chk($sformatf("rst mem_rw%0d", c + 1), {31'd0, mem_rw}, 32'd1);
        end
        chk("rst err", {31'd0, rsp_err}, 32'd0);
        chk("rst rdata", rsp_rdata, 32'd0);
        chk("rst writes", wr_cnt, 32'd0);
        for (int i = 0; i < 32; i++)
            chk($sformatf("rst mem%0d", i), mem[i], snap[i]);
        req_valid = 1'b0;
        rst_n     = 1'b1;

        for (int i = 0; i < 25; i++) run(i, vecs[i]);

        // Reset in the MERGE cycle of a byte store to word 0.
        @(negedge clk);
        begin
            int w0;
            w0           = wr_cnt;
            req_valid    = 1'b1;
            req_we       = 1'b1;
            req_size     = 2'b00;
            req_unsigned = 1'b0;
            req_addr     = 32'h0;
            req_wdata    = 32'h0000_0099;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            chk("abort ready", {31'd0, req_ready}, 32'd1);
            chk("abort valid", {31'd0, rsp_valid}, 32'd0);
            chk("abort rdata", rsp_rdata, 32'd0);
            repeat (4) @(negedge clk);
            chk("abort writes", wr_cnt - w0, 32'd0);
            chk("abort mem0", mem[0], 32'h1122_3344);
            chk("abort idle", {31'd0, req_ready}, 32'd1);
        end

        run(100, '{0, 2'b10, 0, 32'h0, 32'h0, 0, 32'h11223344, 3, 0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
